// File: rtl/mux_2_1_6b_rr_arbiter.sv
// mux_2_1_6b_rr_arbiter: round-robin arbiter sharing a registered 2:1 mux between two valid/ready requesters.
module mux_2_1_6b_rr_arbiter #(
  parameter int WIDTH = 6,
  parameter int MAX_LOCK = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [WIDTH-1:0] Data0,
  output logic             Ack0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Data1,
  output logic             Ack1,
  output logic             Select,
  output logic [WIDTH-1:0] Output,
  output logic             OutValid,
`ifdef BURST_LOCK_EN
  input  logic             Lock0,
  input  logic             Lock1,
`endif
  input  logic             OutReady
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_next;
  logic last_grant, winner, any_req, can_load, capture;
  assign any_req  = Req0 | Req1;
  assign can_load = (state == EMPTY) | OutReady;
  assign capture  = can_load & any_req & ~Reset;
`ifdef BURST_LOCK_EN
  logic [7:0] lock_cnt;
  logic owner_lock, lock_hit;
  assign owner_lock = last_grant ? Lock1 : Lock0;
  assign lock_hit   = owner_lock && (last_grant ? Req1 : Req0) && (lock_cnt < 8'(MAX_LOCK));
`endif
  always_comb begin
    winner = (Req0 & Req1) ? ~last_grant : Req1;
`ifdef BURST_LOCK_EN
    winner = lock_hit ? last_grant : winner;
`endif
    state_next = capture ? FULL : (OutReady ? EMPTY : state);
  end
  assign Select   = any_req ? winner : last_grant;
  assign Ack0     = capture & ~winner;
  assign Ack1     = capture & winner;
  assign OutValid = (state == FULL);
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= EMPTY;
      Output     <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (capture) begin
        Output     <= winner ? Data1 : Data0;
        last_grant <= winner;
      end
    end
  end
`ifdef BURST_LOCK_EN
  always_ff @(posedge Clock) begin
    if (Reset || !owner_lock)
      lock_cnt <= '0;
    else if (capture)
      lock_cnt <= (winner != last_grant) ? 8'd0 : (lock_hit ? lock_cnt + 8'd1 : lock_cnt);
  end
`endif
endmodule

// File: tb/tb_mux_2_1_6b_rr_arbiter.sv
// tb_mux_2_1_6b_rr_arbiter: directed and random scoreboard bench for the round-robin mux arbiter.
module tb_mux_2_1_6b_rr_arbiter;
  localparam int W = 6;
  logic clock = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic ack0, ack1, sel, out_valid;
  logic [W-1:0] out_data;
`ifdef BURST_LOCK_EN
  logic lock0 = 1'b0, lock1 = 1'b0;
`endif
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] sb [$];
  logic acc0 = 1'b0, acc1 = 1'b0;
  always #5 clock = ~clock;
  mux_2_1_6b_rr_arbiter #(.WIDTH(W), .MAX_LOCK(3)) dut (
    .Clock(clock), .Reset(reset),
    .Req0(req0), .Data0(data0), .Ack0(ack0),
    .Req1(req1), .Data1(data1), .Ack1(ack1),
    .Select(sel), .Output(out_data), .OutValid(out_valid),
`ifdef BURST_LOCK_EN
    .Lock0(lock0), .Lock1(lock1),
`endif
    .OutReady(out_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic at();
    @(posedge clock);
    #3;
  endtask
  always @(negedge clock) begin
    acc0 = ack0;
    acc1 = ack1;
    if (reset) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) check("sb_data", out_data, sb.pop_front());
      end
      check("ack_excl", ack0 & ack1, 0);
      check("ack_req", (ack0 & ~req0) | (ack1 & ~req1), 0);
      if (ack0) sb.push_back(data0);
      if (ack1) sb.push_back(data1);
    end
  end
  initial begin
    req0 = 1; req1 = 1; data0 = 6'h0A; data1 = 6'h35; out_ready = 1;
    at(); at();
    check("rst_out", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    reset = 0;
    #1;
    check("first_ack0", ack0, 1);
    check("first_sel", sel, 0);
    for (int i = 0; i < 6; i++) begin
      at();
      check("alt_out", out_data, (i % 2) ? 6'h35 : 6'h0A);
      check("alt_valid", out_valid, 1);
    end
    req0 = 0; req1 = 0;
    at();
    check("drain_valid", out_valid, 0);
    check("idle_sel", sel, 1);
    req1 = 1; data1 = 6'h3F;
    #1;
    check("cap3f_ack1", ack1, 1);
    at();
    req1 = 0; req0 = 1; data0 = 6'h11; out_ready = 0;
    #1;
    check("stall_out", out_data, 6'h3F);
    check("stall_valid", out_valid, 1);
    check("stall_ack0", ack0, 0);
    repeat (2) begin
      at();
      check("stall_out", out_data, 6'h3F);
      check("stall_ack0", ack0, 0);
      check("stall_sel", sel, 0);
    end
    out_ready = 1;
    #1;
    check("unstall_ack0", ack0, 1);
    at();
    req0 = 0;
    check("unstall_out", out_data, 6'h11);
    check("unstall_valid", out_valid, 1);
    at();
    check("unstall_drain", out_valid, 0);
    req1 = 1; data1 = 6'h2A;
    #1;
    check("single_ack1", ack1, 1);
    check("single_sel", sel, 1);
    at();
    req1 = 0;
    #1;
    check("single_out", out_data, 6'h2A);
    check("single_valid", out_valid, 1);
    check("single_ack1_off", ack1, 0);
    at();
    check("single_empty", out_valid, 0);
    repeat (300) begin
      at();
      if (!req0 || acc0) begin req0 = 1'($urandom_range(0, 1)); data0 = W'($urandom); end
      if (!req1 || acc1) begin req1 = 1'($urandom_range(0, 1)); data1 = W'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    at();
    req0 = 0; req1 = 0; out_ready = 1;
    repeat (3) at();
    check("rand_sb_empty", sb.size(), 0);
    req0 = 1; data0 = 6'h15; out_ready = 0;
    #1;
    check("hold15_ack0", ack0, 1);
    at();
    req0 = 0;
    check("hold15_out", out_data, 6'h15);
    check("hold15_valid", out_valid, 1);
    reset = 1;
    at();
    check("midrst_valid", out_valid, 0);
    check("midrst_out", out_data, 0);
    reset = 0; req0 = 1; req1 = 1; data0 = 6'h07; data1 = 6'h38; out_ready = 1;
    #1;
    check("midrst_ack0", ack0, 1);
    check("midrst_sel", sel, 0);
    at();
    req0 = 0; req1 = 0;
    check("post_rst_out", out_data, 6'h07);
    at();
    check("post_rst_empty", out_valid, 0);
    check("final_sb_empty", sb.size(), 0);
`ifdef BURST_LOCK_EN
    reset = 1;
    at();
    reset = 0; lock0 = 1; req0 = 1; req1 = 1; data0 = 6'h01; data1 = 6'h02;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("lock_grant", sel, (i < 4) ? 0 : 1);
      at();
    end
    req0 = 0; req1 = 0; lock0 = 0;
    repeat (3) at();
    check("lock_sb_empty", sb.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
